// File: rtl/dispatch_scheduler.sv
// In-order dispatch of decoded op pairs into per-unit reservation stations,
// gated by credit counters and unit issue-port limits.
module dispatch_scheduler #(
    parameter int TAG_W     = 6,
    parameter int ALU_DEPTH = 4,
    parameter int BU_DEPTH  = 2,
    parameter int DUL_DEPTH = 4,
    parameter int DUS_DEPTH = 4,
    localparam int ALU_CW   = $clog2(ALU_DEPTH + 1),
    localparam int BU_CW    = $clog2(BU_DEPTH + 1),
    localparam int DUL_CW   = $clog2(DUL_DEPTH + 1),
    localparam int DUS_CW   = $clog2(DUS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_lane_vld,
    input  logic [1:0]        in_unit0,
    input  logic [1:0]        in_unit1,
    input  logic [TAG_W-1:0]  in_tag0,
    input  logic [TAG_W-1:0]  in_tag1,
    input  logic [1:0]        ret_alu,
    input  logic              ret_bu,
    input  logic              ret_dul,
    input  logic              ret_dus,
    output logic [1:0]        iss_alu_vld,
    output logic [TAG_W-1:0]  iss_alu_tag0,
    output logic [TAG_W-1:0]  iss_alu_tag1,
    output logic              iss_bu_vld,
    output logic              iss_dul_vld,
    output logic              iss_dus_vld,
    output logic [TAG_W-1:0]  iss_bu_tag,
    output logic [TAG_W-1:0]  iss_dul_tag,
    output logic [TAG_W-1:0]  iss_dus_tag,
    output logic [ALU_CW-1:0] cred_alu,
    output logic [BU_CW-1:0]  cred_bu,
    output logic [DUL_CW-1:0] cred_dul,
    output logic [DUS_CW-1:0] cred_dus
);

    typedef enum logic [1:0] {EMPTY, PAIR, HALF} state_t;
    typedef enum logic [1:0] {U_ALU = 2'd0, U_BU = 2'd1, U_DUL = 2'd2, U_DUS = 2'd3} unit_t;

    state_t           state;
    logic             old_vld, yng_vld;
    unit_t            old_unit, yng_unit;
    logic [TAG_W-1:0] old_tag, yng_tag;

    logic             old_here, yng_here, old_go, yng_go, yng_ok;
    logic             all_done, accept, half_move;
    logic [3:0]       cred_nz;
    logic [1:0]       disp_alu;
    logic [1:0]       alu_vld_d;
    logic             bu_vld_d, dul_vld_d, dus_vld_d;
    logic [TAG_W-1:0] alu_tag0_d, alu_tag1_d, bu_tag_d, dul_tag_d, dus_tag_d;
    int               alu_sum, bu_sum, dul_sum, dus_sum;

    always_comb begin
        // NOTE: every combinational output is given a default first so no path can infer a latch.
        alu_vld_d  = '0;
        bu_vld_d   = 1'b0;
        dul_vld_d  = 1'b0;
        dus_vld_d  = 1'b0;
        alu_tag0_d = '0;
        alu_tag1_d = '0;
        bu_tag_d   = '0;
        dul_tag_d  = '0;
        dus_tag_d  = '0;

        cred_nz  = {cred_dus != '0, cred_dul != '0, cred_bu != '0, cred_alu != '0};
        old_here = (state != EMPTY) && old_vld;
        yng_here = (state == PAIR) && yng_vld;
        old_go   = old_here && cred_nz[old_unit];

        // Two ops to the same unit only fit when that unit has two ports (ALU).
        if (old_here && (old_unit == yng_unit))
            yng_ok = (yng_unit == U_ALU) && (int'(cred_alu) >= 2);
        else
            yng_ok = cred_nz[yng_unit];

        yng_go    = yng_here && (old_go || !old_here) && yng_ok;
        all_done  = (!old_here || old_go) && (!yng_here || yng_go);
        half_move = yng_here && !yng_go && (old_go || !old_here);
        in_ready  = !flush && all_done;
        accept    = in_valid && in_ready;

        if (old_go) begin
            case (old_unit)
                U_ALU: begin alu_vld_d[0] = 1'b1; alu_tag0_d = old_tag; end
                U_BU:  begin bu_vld_d  = 1'b1; bu_tag_d  = old_tag; end
                U_DUL: begin dul_vld_d = 1'b1; dul_tag_d = old_tag; end
                U_DUS: begin dus_vld_d = 1'b1; dus_tag_d = old_tag; end
            endcase
        end
        if (yng_go) begin
            case (yng_unit)
                U_ALU: begin
                    if (alu_vld_d[0]) begin alu_vld_d[1] = 1'b1; alu_tag1_d = yng_tag; end
                    else              begin alu_vld_d[0] = 1'b1; alu_tag0_d = yng_tag; end
                end
                U_BU:  begin bu_vld_d  = 1'b1; bu_tag_d  = yng_tag; end
                U_DUL: begin dul_vld_d = 1'b1; dul_tag_d = yng_tag; end
                U_DUS: begin dus_vld_d = 1'b1; dus_tag_d = yng_tag; end
            endcase
        end

        disp_alu = {1'b0, alu_vld_d[0]} + {1'b0, alu_vld_d[1]};
        alu_sum  = int'(cred_alu) - int'(disp_alu) + int'(ret_alu);
        bu_sum   = int'(cred_bu)  - int'(bu_vld_d)  + int'(ret_bu);
        dul_sum  = int'(cred_dul) - int'(dul_vld_d) + int'(ret_dul);
        dus_sum  = int'(cred_dus) - int'(dus_vld_d) + int'(ret_dus);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state        <= EMPTY;
            iss_alu_vld  <= '0;
            iss_alu_tag0 <= '0;
            iss_alu_tag1 <= '0;
            iss_bu_vld   <= 1'b0;
            iss_dul_vld  <= 1'b0;
            iss_dus_vld  <= 1'b0;
            iss_bu_tag   <= '0;
            iss_dul_tag  <= '0;
            iss_dus_tag  <= '0;
            cred_alu     <= ALU_CW'(ALU_DEPTH);
            cred_bu      <= BU_CW'(BU_DEPTH);
            cred_dul     <= DUL_CW'(DUL_DEPTH);
            cred_dus     <= DUS_CW'(DUS_DEPTH);
        end else begin
            iss_alu_vld  <= alu_vld_d;
            iss_alu_tag0 <= alu_tag0_d;
            iss_alu_tag1 <= alu_tag1_d;
            iss_bu_vld   <= bu_vld_d;
            iss_dul_vld  <= dul_vld_d;
            iss_dus_vld  <= dus_vld_d;
            iss_bu_tag   <= bu_tag_d;
            iss_dul_tag  <= dul_tag_d;
            iss_dus_tag  <= dus_tag_d;
            cred_alu     <= ALU_CW'(alu_sum);
            cred_bu      <= BU_CW'(bu_sum);
            cred_dul     <= DUL_CW'(dul_sum);
            cred_dus     <= DUS_CW'(dus_sum);
            if (accept)         state <= PAIR;
            else if (all_done)  state <= EMPTY;
            else if (half_move) state <= HALF;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: slot payloads carry no reset; state alone decides whether they mean anything.
        if (accept) begin
            old_vld  <= in_lane_vld[0];
            old_unit <= unit_t'(in_unit0);
            old_tag  <= in_tag0;
            yng_vld  <= in_lane_vld[1];
            yng_unit <= unit_t'(in_unit1);
            yng_tag  <= in_tag1;
        end else if (half_move) begin
            old_vld  <= 1'b1;
            old_unit <= yng_unit;
            old_tag  <= yng_tag;
        end
    end

    // Returning more credits than were outstanding is an upstream protocol error.
    assert property (@(posedge clk) disable iff (rst || flush) (alu_sum >= 0 && alu_sum <= ALU_DEPTH))
        else $error("alu credit out of range");
    assert property (@(posedge clk) disable iff (rst || flush) (bu_sum >= 0 && bu_sum <= BU_DEPTH))
        else $error("bu credit out of range");
    assert property (@(posedge clk) disable iff (rst || flush) (dul_sum >= 0 && dul_sum <= DUL_DEPTH))
        else $error("dul credit out of range");
    assert property (@(posedge clk) disable iff (rst || flush) (dus_sum >= 0 && dus_sum <= DUS_DEPTH))
        else $error("dus credit out of range");

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Scoreboard bench for dispatch_scheduler: an in-order op queue with per-unit
// credit and port budgets predicts issues; a negedge monitor compares them.
module tb_dispatch_scheduler;
    localparam int TAG_W = 6;

    logic             clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [1:0]       in_lane_vld = '0, in_unit0 = '0, in_unit1 = '0, ret_alu = '0;
    logic [TAG_W-1:0] in_tag0 = '0, in_tag1 = '0;
    logic             ret_bu = 1'b0, ret_dul = 1'b0, ret_dus = 1'b0;
    logic             in_ready;
    logic [1:0]       iss_alu_vld;
    logic [TAG_W-1:0] iss_alu_tag0, iss_alu_tag1, iss_bu_tag, iss_dul_tag, iss_dus_tag;
    logic             iss_bu_vld, iss_dul_vld, iss_dus_vld;
    logic [2:0]       cred_alu, cred_dul, cred_dus;
    logic [1:0]       cred_bu;

    dispatch_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_vld(in_lane_vld), .in_unit0(in_unit0), .in_unit1(in_unit1),
        .in_tag0(in_tag0), .in_tag1(in_tag1), .ret_alu(ret_alu), .ret_bu(ret_bu),
        .ret_dul(ret_dul), .ret_dus(ret_dus), .iss_alu_vld(iss_alu_vld),
        .iss_alu_tag0(iss_alu_tag0), .iss_alu_tag1(iss_alu_tag1), .iss_bu_vld(iss_bu_vld),
        .iss_dul_vld(iss_dul_vld), .iss_dus_vld(iss_dus_vld), .iss_bu_tag(iss_bu_tag),
        .iss_dul_tag(iss_dul_tag), .iss_dus_tag(iss_dus_tag), .cred_alu(cred_alu),
        .cred_bu(cred_bu), .cred_dul(cred_dul), .cred_dus(cred_dus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_err = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]       unit;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct {
        int               cyc;
        logic [1:0]       av;
        logic [TAG_W-1:0] at0, at1;
        logic             bv, dv, sv;
        logic [TAG_W-1:0] bt, dt, st;
    } rec_t;

    op_t  held[$];
    rec_t exp_q[$];
    int   cr[4];
    int   dep[4]   = '{4, 2, 4, 4};
    int   ports[4] = '{2, 1, 1, 1};

    // One clock cycle: drive inputs, check the start-of-cycle view, predict, advance the model.
    task automatic cycle(input logic v, input logic [1:0] lv, input logic [1:0] u0,
                         input logic [TAG_W-1:0] t0, input logic [1:0] u1,
                         input logic [TAG_W-1:0] t1, input int ra, input int rb,
                         input int rdl, input int rds, input logic fl);
        int   used[4];
        int   ret[4];
        int   ngo;
        int   ap;
        bit   ready;
        rec_t r;
        @(negedge clk);
        in_valid = v; in_lane_vld = lv; in_unit0 = u0; in_tag0 = t0; in_unit1 = u1; in_tag1 = t1;
        ret_alu = 2'(ra); ret_bu = (rb != 0); ret_dul = (rdl != 0); ret_dus = (rds != 0);
        flush = fl;
        #1;
        used = '{0, 0, 0, 0};
        ret  = '{ra, rb, rdl, rds};
        ngo  = 0;
        for (int i = 0; i < held.size(); i++) begin
            int u = int'(held[i].unit);
            if (cr[u] - used[u] < 1 || used[u] >= ports[u]) break;
            used[u]++;
            ngo++;
        end
        ready = !fl && (ngo == held.size());
        check("in_ready", in_ready, ready);
        check("cred_alu", cred_alu, cr[0]);
        check("cred_bu", cred_bu, cr[1]);
        check("cred_dul", cred_dul, cr[2]);
        check("cred_dus", cred_dus, cr[3]);
        if (!fl && ngo > 0) begin
            r = '{default: 0};
            r.cyc = cyc + 1;
            ap = 0;
            for (int i = 0; i < ngo; i++) begin
                case (held[i].unit)
                    2'd0: begin
                        if (ap == 0) begin r.av[0] = 1'b1; r.at0 = held[i].tag; end
                        else         begin r.av[1] = 1'b1; r.at1 = held[i].tag; end
                        ap++;
                    end
                    2'd1: begin r.bv = 1'b1; r.bt = held[i].tag; end
                    2'd2: begin r.dv = 1'b1; r.dt = held[i].tag; end
                    default: begin r.sv = 1'b1; r.st = held[i].tag; end
                endcase
            end
            exp_q.push_back(r);
        end
        if (fl) begin
            held.delete();
            cr = dep;
        end else begin
            for (int i = 0; i < ngo; i++) void'(held.pop_front());
            for (int u = 0; u < 4; u++) cr[u] = cr[u] - used[u] + ret[u];
            if (v && ready) begin
                if (lv[0]) held.push_back('{u0, t0});
                if (lv[1]) held.push_back('{u1, t1});
            end
        end
    endtask

    task automatic pair(input logic [1:0] u0, input logic [TAG_W-1:0] t0,
                        input logic [1:0] u1, input logic [TAG_W-1:0] t1);
        cycle(1'b1, 2'b11, u0, t0, u1, t1, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int ra, input int rb, input int rdl, input int rds, input logic fl);
        cycle(1'b0, 2'b00, 2'd0, '0, 2'd0, '0, ra, rb, rdl, rds, fl);
    endtask

    bit   mon_en = 1'b0;
    rec_t mr;
    always @(negedge clk) begin
        if (mon_en) begin
            if (iss_alu_vld != 2'b00 || iss_bu_vld || iss_dul_vld || iss_dus_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", {iss_alu_vld, iss_bu_vld, iss_dul_vld, iss_dus_vld}, 0);
                end else begin
                    mr = exp_q.pop_front();
                    check("iss_cycle", cyc, mr.cyc);
                    check("iss_alu_vld", iss_alu_vld, mr.av);
                    check("iss_alu_tag0", iss_alu_tag0, mr.at0);
                    check("iss_alu_tag1", iss_alu_tag1, mr.at1);
                    check("iss_bu", {iss_bu_vld, iss_bu_tag}, {mr.bv, mr.bt});
                    check("iss_dul", {iss_dul_vld, iss_dul_tag}, {mr.dv, mr.dt});
                    check("iss_dus", {iss_dus_vld, iss_dus_tag}, {mr.sv, mr.st});
                end
            end else begin
                check("idle_tags", {iss_alu_tag0, iss_alu_tag1, iss_bu_tag, iss_dul_tag, iss_dus_tag}, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    mr = exp_q.pop_front();
                    check("missed_issue", {iss_alu_vld, iss_bu_vld, iss_dul_vld, iss_dus_vld},
                          {mr.av, mr.bv, mr.dv, mr.sv});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_cred_alu", cred_alu, 4);
        check("rst_cred_bu", cred_bu, 2);
        check("rst_cred_dul", cred_dul, 4);
        check("rst_cred_dus", cred_dus, 4);
        check("rst_iss_vld", {iss_alu_vld, iss_bu_vld, iss_dul_vld, iss_dus_vld}, 0);
        cr = dep;
        mon_en = 1'b1;

        // ALU/ALU pair
        pair(2'd0, 6'd5, 2'd0, 6'd6);
        idle(0, 0, 0, 0, 1'b0);
        idle(0, 0, 0, 0, 1'b0);
        check("aa_vld", iss_alu_vld, 2'b11);
        check("aa_tag0", iss_alu_tag0, 5);
        check("aa_tag1", iss_alu_tag1, 6);
        check("aa_cred", cred_alu, 2);

        // ALU/ALU with two credits returned in the decision cycle
        pair(2'd0, 6'd7, 2'd0, 6'd8);
        idle(2, 0, 0, 0, 1'b0);
        idle(0, 0, 0, 0, 1'b0);
        check("aa_ret_vld", iss_alu_vld, 2'b11);
        check("aa_ret_cred", cred_alu, 2);

        // BU/BU pair serialises on the single port
        pair(2'd1, 6'd1, 2'd1, 6'd2);
        idle(0, 0, 0, 0, 1'b0);
        check("bb_ready_stall", in_ready, 0);
        check("bb_cred0", cred_bu, 2);
        idle(0, 0, 0, 0, 1'b0);
        check("bb_first", {iss_bu_vld, iss_bu_tag}, {1'b1, 6'd1});
        check("bb_cred1", cred_bu, 1);
        idle(0, 0, 0, 0, 1'b0);
        check("bb_second", {iss_bu_vld, iss_bu_tag}, {1'b1, 6'd2});
        check("bb_cred2", cred_bu, 0);

        // Flush while a BU op waits in HALF, with a same-cycle ret_bu
        pair(2'd0, 6'd3, 2'd1, 6'd4);
        idle(0, 0, 0, 0, 1'b0);
        idle(0, 1, 0, 0, 1'b1);
        idle(0, 0, 0, 0, 1'b0);
        check("fl_cred_bu", cred_bu, 2);
        check("fl_ready", in_ready, 1);
        check("fl_no_bu", iss_bu_vld, 0);

        // Exhaust DUL credits, then a DUL/ALU pair waits for a return
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'b01, 2'd2, 6'(10 + i), 2'd0, 6'd0, 0, 0, 0, 0, 1'b0);
        pair(2'd2, 6'd20, 2'd0, 6'd21);
        idle(0, 0, 0, 0, 1'b0);
        check("dul_wait_ready", in_ready, 0);
        idle(0, 0, 0, 0, 1'b0);
        check("dul_wait_none", {iss_dul_vld, iss_alu_vld}, 0);
        idle(0, 0, 1, 0, 1'b0);
        idle(0, 0, 0, 0, 1'b0);
        idle(0, 0, 0, 0, 1'b0);
        check("dul_go", {iss_dul_vld, iss_dul_tag}, {1'b1, 6'd20});
        check("dul_alu_go", {iss_alu_vld, iss_alu_tag0}, {2'b01, 6'd21});

        // Lane1-only pair issues without waiting on lane0
        cycle(1'b1, 2'b10, 2'd0, 6'd63, 2'd3, 6'd9, 0, 0, 0, 0, 1'b0);
        idle(0, 0, 0, 0, 1'b0);
        idle(0, 0, 0, 0, 1'b0);
        check("dus_lane1", {iss_dus_vld, iss_dus_tag}, {1'b1, 6'd9});

        // Randomized traffic with legal credit returns
        for (int n = 0; n < 1500; n++) begin
            int ra_m;
            int ra, rb, rdl, rds;
            ra_m = dep[0] - cr[0];
            if (ra_m > 2) ra_m = 2;
            ra  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ra_m)) : 0;
            rb  = (cr[1] < dep[1] && $urandom_range(0, 2) == 0) ? 1 : 0;
            rdl = (cr[2] < dep[2] && $urandom_range(0, 2) == 0) ? 1 : 0;
            rds = (cr[3] < dep[3] && $urandom_range(0, 2) == 0) ? 1 : 0;
            cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                  ra, rb, rdl, rds, $urandom_range(0, 49) == 0);
        end

        // Drain with every outstanding credit returned, bounded
        for (int n = 0; n < 100 && (held.size() > 0 || exp_q.size() > 0); n++) begin
            int ra_m;
            ra_m = dep[0] - cr[0];
            if (ra_m > 2) ra_m = 2;
            idle(ra_m, int'(cr[1] < dep[1]), int'(cr[2] < dep[2]), int'(cr[3] < dep[3]), 1'b0);
        end
        check("drain_empty", held.size() + exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
